// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-memory responder and its fetch-side neighbours.
// State encoding, default bus widths and the wait-state counter width.
package imem_fetch_responder_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned CntW     = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Program store: DEPTH x DATA_W words, synchronous write, combinational read.
module imem_array
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts a fetch read, waits WAIT_CYCLES, returns the word.
// Optional response counter enabled by defining IMEM_FETCH_STATS_EN.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              mem_busy,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
`ifdef IMEM_FETCH_STATS_EN
    ,
    output logic [15:0]       resp_count
`endif
);

    localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_CYCLES);

    state_t            state;
    logic [CntW-1:0]   wait_count;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] rd_data;

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (fetch_addr),
        .rd_data (rd_data)
    );

    // Read data is sampled before a same-edge load lands, giving read-before-write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            wait_count  <= '0;
            fetch_addr  <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef IMEM_FETCH_STATS_EN
            resp_count  <= '0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (mem_read) begin
                        fetch_addr <= pc_addr;
                        wait_count <= WaitLoad;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    if (wait_count != '0) begin
                        wait_count <= wait_count - CntW'(1);
                    end else begin
                        instr       <= rd_data;
                        instr_valid <= 1'b1;
                        state       <= StIdle;
`ifdef IMEM_FETCH_STATS_EN
                        resp_count  <= resp_count + 16'd1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign mem_busy = (state == StWait);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: one instance with two wait states, one with none.
module tb_imem_fetch_responder;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_read0;
    logic [7:0]  pc_addr;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    logic        mem_busy, mem_busy0;
    logic [15:0] instr, instr0;
    logic        instr_valid, instr_valid0;
`ifdef IMEM_FETCH_STATS_EN
    logic [15:0] resp_count, resp_count0;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    imem_fetch_responder #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .WAIT_CYCLES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_read    (mem_read),
        .pc_addr     (pc_addr),
        .mem_busy    (mem_busy),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
`ifdef IMEM_FETCH_STATS_EN
        ,
        .resp_count  (resp_count)
`endif
    );

    imem_fetch_responder #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clock       (clock),
        .reset       (reset),
        .mem_read    (mem_read0),
        .pc_addr     (pc_addr),
        .mem_busy    (mem_busy0),
        .instr       (instr0),
        .instr_valid (instr_valid0),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
`ifdef IMEM_FETCH_STATS_EN
        ,
        .resp_count  (resp_count0)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clock);
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (mem_busy !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_idle: got busy=%b valid=%b instr=%h, expected 0 0 0000",
                         mem_busy, instr_valid, instr);
            end
            vectors++;
            if (mem_busy0 !== 1'b0 || instr_valid0 !== 1'b0 || instr0 !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_idle0: got busy=%b valid=%b instr=%h, expected 0 0 0000",
                         mem_busy0, instr_valid0, instr0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int   e0;
        logic exp_busy, exp_valid;
        load_word(8'h10, 16'hBEEF);
        mem_read = 1'b1;
        pc_addr  = 8'h10;
        e0 = cyc + 1;
        qa.push_back('{data: 16'hBEEF, cyc: e0 + 3});
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            exp_busy  = (cyc >= e0 && cyc <= e0 + 2);
            exp_valid = (qa.size() > 0 && qa[0].cyc == cyc);
            vectors++;
            if (mem_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL single_busy@%0d: got %b, expected %b", cyc - e0, mem_busy, exp_busy);
            end
            vectors++;
            if (instr_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL single_valid@%0d: got %b, expected %b", cyc - e0, instr_valid,
                         exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (instr !== qa[0].data) begin
                    miscompares++;
                    $display("FAIL single_instr: got %h, expected %h", instr, qa[0].data);
                end
                qa.pop_front();
            end
            if (cyc == e0) begin
                mem_read = 1'b0;
                pc_addr  = 8'h55;
            end
        end
        vectors++;
        if (instr !== 16'hBEEF || qa.size() != 0) begin
            miscompares++;
            $display("FAIL single_hold: got %h pending=%0d, expected beef pending=0", instr,
                     qa.size());
        end
        qa.delete();
    endtask

    task automatic test_held_request();
        int   base, rel;
        logic exp_busy, exp_valid;
        for (int i = 0; i < 3; i++) load_word(8'(i), 16'(16'h0100 + i));
        mem_read = 1'b1;
        pc_addr  = 8'h00;
        base = cyc;
        for (int k = 0; k < 3; k++) qa.push_back('{data: 16'(16'h0100 + k), cyc: base + 4 + 4 * k});
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            rel       = cyc - base;
            exp_busy  = (rel < 12 && rel % 4 != 0);
            exp_valid = (qa.size() > 0 && qa[0].cyc == cyc);
            vectors++;
            if (mem_busy !== exp_busy || instr_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL held_ctrl@%0d: got busy=%b valid=%b, expected %b %b", rel,
                         mem_busy, instr_valid, exp_busy, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (instr !== qa[0].data) begin
                    miscompares++;
                    $display("FAIL held_instr@%0d: got %h, expected %h", rel, instr, qa[0].data);
                end
                qa.pop_front();
            end
            if (rel == 12) mem_read = 1'b0;
            else if (rel % 4 == 0) pc_addr = 8'(rel / 4);
            else pc_addr = 8'(192 + rel);
        end
        vectors++;
        if (qa.size() != 0) begin
            miscompares++;
            $display("FAIL held_pending: got %0d, expected 0", qa.size());
        end
        qa.delete();
    endtask

    task automatic test_zero_wait();
        int   base, rel;
        logic exp_busy, exp_valid;
        for (int i = 0; i < 3; i++) load_word(8'(8'h30 + i), 16'(16'hA000 + i));
        mem_read0 = 1'b1;
        pc_addr   = 8'h30;
        base = cyc;
        for (int k = 0; k < 3; k++) qb.push_back('{data: 16'(16'hA000 + k), cyc: base + 2 + 2 * k});
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            rel       = cyc - base;
            exp_busy  = (rel < 6 && rel % 2 == 1);
            exp_valid = (qb.size() > 0 && qb[0].cyc == cyc);
            vectors++;
            if (mem_busy0 !== exp_busy || instr_valid0 !== exp_valid || mem_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_ctrl@%0d: got busy=%b valid=%b other_busy=%b, expected %b %b 0",
                         rel, mem_busy0, instr_valid0, mem_busy, exp_busy, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (instr0 !== qb[0].data) begin
                    miscompares++;
                    $display("FAIL zero_instr@%0d: got %h, expected %h", rel, instr0, qb[0].data);
                end
                qb.pop_front();
            end
            if (rel == 6) mem_read0 = 1'b0;
            else if (rel % 2 == 0) pc_addr = 8'(8'h30 + rel / 2);
            else pc_addr = 8'(192 + rel);
        end
        vectors++;
        if (qb.size() != 0) begin
            miscompares++;
            $display("FAIL zero_pending: got %0d, expected 0", qb.size());
        end
        qb.delete();
    endtask

    task automatic test_collision();
        int   e0, wr_edge;
        logic exp_valid;
        for (int r = 0; r < 2; r++) begin
            load_word(8'h20, 16'h1111);
            mem_read = 1'b1;
            pc_addr  = 8'h20;
            e0       = cyc + 1;
            wr_edge  = (r == 0) ? e0 + 3 : e0 + 2;
            qa.push_back('{data: (r == 0) ? 16'h1111 : 16'h2222, cyc: e0 + 3});
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                exp_valid = (qa.size() > 0 && qa[0].cyc == cyc);
                vectors++;
                if (instr_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL coll%0d_valid@%0d: got %b, expected %b", r, cyc - e0,
                             instr_valid, exp_valid);
                end
                if (exp_valid) begin
                    vectors++;
                    if (instr !== qa[0].data) begin
                        miscompares++;
                        $display("FAIL coll%0d_instr: got %h, expected %h", r, instr, qa[0].data);
                    end
                    qa.pop_front();
                end
                if (cyc == e0) mem_read = 1'b0;
                load_en   = (cyc == wr_edge - 1);
                load_addr = 8'h20;
                load_data = 16'h2222;
            end
            load_en = 1'b0;
            vectors++;
            if (qa.size() != 0) begin
                miscompares++;
                $display("FAIL coll%0d_pending: got %0d, expected 0", r, qa.size());
            end
            qa.delete();
        end
    endtask

    task automatic test_reset_mid();
        int   e0;
        logic exp_valid;
        @(negedge clock);
        mem_read = 1'b1;
        pc_addr  = 8'h10;
        e0 = cyc + 1;
        @(negedge clock);
        mem_read = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (mem_busy !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_async: got busy=%b valid=%b instr=%h, expected 0 0 0000",
                     mem_busy, instr_valid, instr);
        end
`ifdef IMEM_FETCH_STATS_EN
        vectors++;
        if (resp_count !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d, expected 0", resp_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (instr_valid !== 1'b0 || mem_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_quiet@%0d: got busy=%b valid=%b, expected 0 0",
                         cyc - e0, mem_busy, instr_valid);
            end
        end
        for (int k = 0; k < 3; k++) begin
            mem_read = 1'b1;
            pc_addr  = 8'(k);
            e0 = cyc + 1;
            qa.push_back('{data: 16'(16'h0100 + k), cyc: e0 + 3});
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (cyc == e0) mem_read = 1'b0;
                exp_valid = (qa.size() > 0 && qa[0].cyc == cyc);
                vectors++;
                if (instr_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL post_valid%0d: got %b, expected %b", k, instr_valid, exp_valid);
                end
                if (exp_valid) begin
                    vectors++;
                    if (instr !== qa[0].data) begin
                        miscompares++;
                        $display("FAIL post_instr%0d: got %h, expected %h", k, instr, qa[0].data);
                    end
                    qa.pop_front();
                end
            end
        end
        qa.delete();
`ifdef IMEM_FETCH_STATS_EN
        vectors++;
        if (resp_count !== 16'd3) begin
            miscompares++;
            $display("FAIL post_count: got %0d, expected 3", resp_count);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        mem_read    = 1'b0;
        mem_read0   = 1'b0;
        pc_addr     = 8'h00;
        load_en     = 1'b0;
        load_addr   = 8'h00;
        load_data   = 16'h0000;
        #1 reset = 1'b1;
        test_reset();
        test_single_read();
        test_held_request();
        test_zero_wait();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder on the far side of the fetch interface. Accepts read requests (mem_read + PC address) from the fetch controller and returns the instruction word after a programmable number of wait states. Holds a program store that is written through a separate load port. Drives mem_busy back to the fetch stage so it can hold PC and IR1.

Parameters:
ADDR_W, 8, address width; DEPTH is 2**ADDR_W words
DATA_W, 16, instruction word width
WAIT_CYCLES, 2, wait states per access (0..15); read latency is WAIT_CYCLES+1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
mem_read  in  1  fetch read request
pc_addr  in  ADDR_W  fetch address; sampled only on the accept edge
mem_busy  out  1  access in progress; new requests are ignored
instr  out  DATA_W  returned instruction word, registered
instr_valid  out  1  one-cycle pulse; instr is valid in that cycle
load_en  in  1  program-load write strobe
load_addr  in  ADDR_W  program-load address
load_data  in  DATA_W  program-load data

Behaviour:
- Reset values: state IDLE, wait counter 0, captured address 0, instr 0, instr_valid 0, mem_busy 0. Memory contents are not reset.
- Reset is asserted and released asynchronously, clock is clock. Reset mid-access aborts the access; no instr_valid is produced for it.
- States:
  - IDLE: if mem_read is high at an edge, capture pc_addr, load counter with WAIT_CYCLES, and go to WAIT.
  - WAIT: if counter != 0, decrement it. If counter == 0, at that edge: instr <= mem[captured addr], instr_valid <= 1, go to IDLE.
- mem_busy is high exactly when state == WAIT; it is combinational from state.
- mem_read is ignored while in WAIT. A request held high is not queued.
- instr_valid is high for exactly one cycle. instr holds its last value until the next response.
- Latency: accept on edge E0 means instr_valid rises on edge E0+WAIT_CYCLES+1.
- Throughput with mem_read held high is one response every WAIT_CYCLES+2 cycles.
  - In the cycle instr_valid is high, state is IDLE, so the next edge accepts a new request.
- Load port: when load_en is high at an edge, mem[load_addr] <= load_data. Writes are accepted in any state.
- Collision: if load_en targets the captured address on the same edge the response is sampled, instr returns the old word (read-before-write). A load to that address on any earlier edge is visible in the response.
- Address width is exact; no out-of-range case exists.

Optional Feature:
IMEM_FETCH_STATS_EN:
- Defined: adds output resp_count[15:0]. It resets to 0 and increments on every edge that sets instr_valid. It wraps from 0xFFFF to 0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, WAIT=1);
  - the default ADDR_W/DATA_W constants, shared with the datapath and fetch control;
  - the counter width constant (4 bits).
- One sub-module, imem_array: DEPTH x DATA_W storage with synchronous write port and combinational read port. The responder instantiates it and registers the read data into instr.

Test Plan:
- Reset and idle: pulse reset with mem_read=0 for 5 cycles -> mem_busy=0, instr_valid=0, instr=0x0000 throughout.
- Single read (WAIT_CYCLES=2): load mem[0x10]=0xBEEF, then drive mem_read=1, pc_addr=0x10 for one cycle at E0 -> mem_busy high for E0..E3, instr_valid=1 with instr=0xBEEF exactly at E3 for one cycle.
- Held request: mem_read held 1, pc_addr stepping 0x00,0x01,... on each accept, mem[i]=i+0x100 -> responses 0x100,0x101,0x102 spaced 4 cycles apart; pc_addr changes while busy are not captured.
- Zero wait (WAIT_CYCLES=0): accept at E0 -> instr_valid at E1; with mem_read held, a valid pulse every 2 cycles.
- Collision: in-flight read of 0x20 (old 0x1111); load_en writes 0x20=0x2222 on the response edge -> instr=0x1111. Repeat with the write one edge earlier -> instr=0x2222.
- Reset mid-access: assert reset while counter=1 -> no instr_valid, state IDLE, mem_busy=0. With IMEM_FETCH_STATS_EN, resp_count returns to 0 and counts 3 after three further completed reads.
